cm_sketch_row_counter: RTL and testbench

//  Counter-array end of one count-min sketch row: consumes the HASH_SIZE-bit index from the row's
//  H3 hash pipeline, performs saturating read-modify-write increments (update) or plain reads (query)
//  on a W-entry counter RAM, returns the resulting count. One instance per hash row; min-of-rows is downstream.

---
 rtl/cm_sketch_row_counter.sv | 144 ++++++++++++++
 tb/tb_cm_sketch_row_counter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cm_sketch_row_counter.sv
// Counter-array stage of one count-min sketch row: saturating read-modify-write
// updates and plain queries on a W-entry counter RAM, with a clear sweep FSM.
`timescale 1ns/1ps

module cm_sketch_row_counter #(
    parameter int unsigned W         = 4096,
    parameter int unsigned HASH_SIZE = $clog2(W),
    parameter int unsigned CNT_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_op,
    input  logic [HASH_SIZE-1:0] req_index,
    output logic                 rsp_valid,
    output logic                 rsp_op,
    output logic [HASH_SIZE-1:0] rsp_index,
    output logic [CNT_SIZE-1:0]  rsp_count,
    input  logic                 clear_start,
    output logic                 clear_busy
);

    typedef enum logic [1:0] {
        CLEAR,
        DRAIN,
        RUN
    } state_t;

    state_t                state;
    logic [HASH_SIZE-1:0]  sweep_addr;

    logic [CNT_SIZE-1:0]   mem [W];
    logic [CNT_SIZE-1:0]   ram_q;

    logic                  accept;
    logic                  s1_valid;
    logic                  s1_op;
    logic [HASH_SIZE-1:0]  s1_index;
    logic                  s1_fwd;
    logic [CNT_SIZE-1:0]   fwd_count;
    logic [CNT_SIZE-1:0]   s1_old;
    logic [CNT_SIZE-1:0]   s1_new;
    logic                  s1_upd;

    logic                  we;
    logic [HASH_SIZE-1:0]  waddr;
    logic [CNT_SIZE-1:0]   wdata;

    assign accept = req_valid & req_ready;

    always_comb begin
        s1_old = s1_fwd ? fwd_count : ram_q;
        s1_new = (s1_old == '1) ? s1_old : s1_old + CNT_SIZE'(1);
        s1_upd = s1_valid & ~s1_op;
        we     = 1'b0;
        waddr  = s1_index;
        wdata  = s1_new;
        // The sweep owns the write port; DRAIN guarantees S1 is empty by then.
        if (state == CLEAR) begin
            we    = 1'b1;
            waddr = sweep_addr;
            wdata = '0;
        end else begin
            we = s1_upd & (s1_old != '1);
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        ram_q <= mem[req_index];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_op     <= 1'b0;
            s1_index  <= '0;
            s1_fwd    <= 1'b0;
            fwd_count <= '0;
            rsp_valid <= 1'b0;
            rsp_op    <= 1'b0;
            rsp_index <= '0;
            rsp_count <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op     <= req_op;
                s1_index  <= req_index;
                // RAM read of this request races the S1 write of the same index.
                s1_fwd    <= s1_upd && (s1_index == req_index);
                fwd_count <= s1_new;
            end
            rsp_valid <= s1_valid;
            if (s1_valid) begin
                rsp_op    <= s1_op;
                rsp_index <= s1_index;
                rsp_count <= s1_op ? s1_old : s1_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            sweep_addr <= '0;
            req_ready  <= 1'b0;
            clear_busy <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    sweep_addr <= sweep_addr + HASH_SIZE'(1);
                    if (sweep_addr == HASH_SIZE'(W - 1)) begin
                        state      <= RUN;
                        req_ready  <= 1'b1;
                        clear_busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (clear_start) begin
                        state      <= DRAIN;
                        req_ready  <= 1'b0;
                        clear_busy <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !rsp_valid) begin
                        state      <= CLEAR;
                        sweep_addr <= '0;
                    end
                end
                default: begin
                    state      <= CLEAR;
                    sweep_addr <= '0;
                    req_ready  <= 1'b0;
                    clear_busy <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cm_sketch_row_counter.sv
// Directed and randomised checks of cm_sketch_row_counter with W=16, CNT_SIZE=4.
`timescale 1ns/1ps

module tb_cm_sketch_row_counter;

    localparam int unsigned W  = 16;
    localparam int unsigned HS = 4;
    localparam int unsigned CS = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_op;
    logic [HS-1:0] req_index;
    logic          rsp_valid;
    logic          rsp_op;
    logic [HS-1:0] rsp_index;
    logic [CS-1:0] rsp_count;
    logic          clear_start;
    logic          clear_busy;

    cm_sketch_row_counter #(
        .W        (W),
        .CNT_SIZE (CS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_index   (req_index),
        .rsp_valid   (rsp_valid),
        .rsp_op      (rsp_op),
        .rsp_index   (rsp_index),
        .rsp_count   (rsp_count),
        .clear_start (clear_start),
        .clear_busy  (clear_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned   cyc;
        logic          op;
        logic [HS-1:0] idx;
        logic [CS-1:0] cnt;
    } exp_t;

    exp_t          exp_q [$];
    exp_t          head;
    logic [CS-1:0] model [W];
    int unsigned   cyc = 0;
    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Response scoreboard: every accepted request must answer exactly two cycles later.
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                head = exp_q.pop_front();
                check("rsp_latency", cyc, head.cyc);
                check("rsp_op", {31'd0, rsp_op}, {31'd0, head.op});
                check("rsp_index", {28'd0, rsp_index}, {28'd0, head.idx});
                check("rsp_count", {28'd0, rsp_count}, {28'd0, head.cnt});
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            check("missing_rsp", 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
    end

    task automatic clear_model();
        for (int unsigned i = 0; i < W; i++) model[i] = '0;
    endtask

    task automatic issue(input logic op, input logic [HS-1:0] idx, input logic [CS-1:0] exp);
        req_valid = 1'b1;
        req_op    = op;
        req_index = idx;
        check("req_ready", {31'd0, req_ready}, 32'd1);
        exp_q.push_back('{cyc + 2, op, idx, exp});
        if (!op) model[idx] = exp;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_ready(output int unsigned n);
        n = 0;
        while (!req_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int unsigned k;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            k++;
            @(negedge clk);
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int unsigned   n;
        logic          op;
        logic [HS-1:0] idx;
        logic [CS-1:0] e;

        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 1'b0;
        req_index   = '0;
        clear_start = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);

        // 1: reset values, sweep length, first query
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_op", {31'd0, rsp_op}, 32'd0);
        check("rst_rsp_index", {28'd0, rsp_index}, 32'd0);
        check("rst_rsp_count", {28'd0, rsp_count}, 32'd0);
        check("rst_clear_busy", {31'd0, clear_busy}, 32'd1);
        rst_n = 1'b1;
        wait_ready(n);
        check("sweep_cycles", n, 32'd16);
        check("busy_after_sweep", {31'd0, clear_busy}, 32'd0);
        issue(1'b1, 4'd5, 4'd0);
        drain();

        // 2: back-to-back updates then query on one index
        issue(1'b0, 4'd7, 4'd1);
        issue(1'b0, 4'd7, 4'd2);
        issue(1'b0, 4'd7, 4'd3);
        issue(1'b1, 4'd7, 4'd3);
        drain();

        // 3: alternating indices, then gap-of-one on one index
        for (int unsigned i = 1; i <= 4; i++) begin
            issue(1'b0, 4'd3, 4'(i));
            issue(1'b0, 4'd4, 4'(i));
        end
        issue(1'b1, 4'd3, 4'd4);
        issue(1'b1, 4'd4, 4'd4);
        issue(1'b0, 4'd3, 4'd5);
        @(negedge clk);
        issue(1'b0, 4'd3, 4'd6);
        @(negedge clk);
        issue(1'b1, 4'd3, 4'd6);
        drain();

        // 4: saturation at 15
        for (int unsigned i = 1; i <= 16; i++) issue(1'b0, 4'd0, (i <= 15) ? 4'(i) : 4'd15);
        issue(1'b1, 4'd0, 4'd15);
        drain();

        // 5: clear with two requests in flight
        issue(1'b0, 4'd9, 4'd1);
        clear_start = 1'b1;
        issue(1'b0, 4'd9, 4'd2);
        clear_start = 1'b0;
        check("busy_on_clear", {31'd0, clear_busy}, 32'd1);
        check("ready_on_clear", {31'd0, req_ready}, 32'd0);
        wait_ready(n);
        check("clear_sweep_len", {31'd0, (n >= 16 && n <= 20)}, 32'd1);
        check("busy_after_clear", {31'd0, clear_busy}, 32'd0);
        clear_model();
        issue(1'b1, 4'd9, 4'd0);
        issue(1'b1, 4'd7, 4'd0);
        issue(1'b1, 4'd0, 4'd0);
        drain();

        // 6: reset with an update in flight
        issue(1'b0, 4'd2, 4'd1);
        drain();
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_index = 4'd2;
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rsp_in_reset", {31'd0, rsp_valid}, 32'd0);
        end
        rst_n = 1'b1;
        wait_ready(n);
        check("resweep_cycles", n, 32'd16);
        clear_model();
        issue(1'b1, 4'd2, 4'd0);
        drain();

        // Random mix on a narrow index range to exercise forwarding and saturation
        for (int unsigned i = 0; i < 80; i++) begin
            op  = 1'($urandom_range(0, 1));
            idx = 4'($urandom_range(0, 5));
            e   = op ? model[idx] : ((model[idx] == 4'hF) ? 4'hF : model[idx] + 4'd1);
            issue(op, idx, e);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
